cam_capture_ctrl: RTL
=====================

// Module: cam_capture_ctrl
// PURPOSE
//  Write-side sequencer for the dual-port frame buffer (160x120, RGB332). Takes the camera pixel
//  stream (already in clk domain), waits for a frame start, writes one frame of pixels at
//  consecutive addresses into the buffer write port and reports completion/errors to the SoC CSRs.
//  The VGA side reads the buffer independently; this block owns addr_in/data_in/regwrite only.
// PARAMETERS
//  AW      15   buffer address width; IMG_W*IMG_H must be < 2**AW
//  DW      8    pixel/data width (RGB332)
//  IMG_W   160  pixels per stored line
//  IMG_H   120  stored lines per frame
// PORTS
//  clk         in   1   system clock; also buffer clk_w
//  rst         in   1   synchronous, active-high reset
//  start       in   1   1-cycle pulse: arm capture (ignored unless IDLE or DONE)
//  abort       in   1   1-cycle pulse: return to IDLE, no further writes
//  cont        in   1   1 = continuous mode: re-arm automatically after each frame
//  cam_vsync   in   1   frame sync, high between frames
//  cam_href    in   1   line valid
//  px_valid    in   1   px_data valid this cycle (one strobe per assembled pixel)
//  px_data     in   DW  pixel value
//  mem_addr    out  AW  buffer addr_in
//  mem_data    out  DW  buffer data_in
//  mem_we      out  1   buffer regwrite
//  busy        out  1   high in WAIT_VS and CAPTURE
//  done        out  1   sticky; set on frame end, cleared by start/abort/rst
//  err_short   out  1   sticky; frame ended (vsync rise) before IMG_W*IMG_H pixels
//  px_count    out  AW  pixels written in current/last frame
// BEHAVIOUR
//  Reset: state IDLE; mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0, err_short=0, px_count=0.
//  FSM: IDLE --start--> WAIT_VS --vsync falling edge--> CAPTURE --count==IMG_W*IMG_H or vsync
//   rising edge--> DONE; DONE --start, or cont=1 next cycle--> WAIT_VS. abort from any state -> IDLE
//   (abort wins over start in same cycle); mem_we forced 0 the cycle after abort.
//  Edge detect: vsync/href registered once; edges judged on registered vs current sample.
//  CAPTURE: px_valid & cam_href -> write; registered outputs, so mem_we/mem_addr/mem_data appear
//   1 cycle after the px_valid sample. addr starts at 0, increments by 1 per write, never wraps:
//   writes beyond IMG_W*IMG_H-1 are suppressed (count saturates, FSM already in DONE).
//  Pixel accepted on the same cycle as vsync rise: not written; err_short set if count short.
//  Entering WAIT_VS clears done, err_short, px_count, address to 0.
//  Full frame exactly at vsync rise: done=1, err_short=0. Pixels with href=0 are dropped.
//  mem_we is a single-cycle pulse per pixel; back-to-back px_valid gives back-to-back writes.
// CONFIGURATION
//  CAM_CAPTURE_DECIM_EN defined: 2:1 decimation in both axes (for 320x240 QVGA sources); pixel
//   parity toggles per accepted pixel and resets on href rise; line parity toggles on href fall
//   and resets on vsync fall; write only when both parities are 0. IMG_W/IMG_H still give stored size.
//  Undefined: every accepted pixel is written; parity logic absent.
// STRUCTURE
//  cam_capture_pkg.vh: state encodings (IDLE=0, WAIT_VS=1, CAPTURE=2, DONE=3), IMG_W/IMG_H
//   defaults, IMG_SIZE = IMG_W*IMG_H, shared with the VGA reader and CSR decode.
//  Sub-module sync_edge_det: 1-bit register + rise/fall outputs, instantiated for vsync and href.
// TESTING
//  1 reset mid-CAPTURE after 100 writes -> all outputs 0 next cycle, no mem_we until new start.
//  2 start, vsync fall, 120 lines x 160 px -> 19200 writes, addr 0..19199, done=1, err_short=0.
//  3 start, vsync rises after 5000 px -> px_count=5000, done=1, err_short=1, last addr 4999.
//  4 cont=1, three frames -> done pulses each frame, addr restarts at 0, no writes between frames.
//  5 abort and start same cycle in CAPTURE -> IDLE, busy=0, no further mem_we.
//  6 CAM_CAPTURE_DECIM_EN, 240 lines x 320 px -> 19200 writes; addr 1 holds source pixel (0,2).

Source files
------------

// File: rtl/cam_capture_pkg.sv
// Shared frame-buffer capture definitions: state encoding and default image geometry,
// also used by the VGA reader and CSR decode.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int AW_DEF       = 15;
  localparam int DW_DEF       = 8;
  localparam int IMG_W_DEF    = 160;
  localparam int IMG_H_DEF    = 120;
  localparam int IMG_SIZE_DEF = IMG_W_DEF * IMG_H_DEF;

  function automatic int img_size(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/cam_capture_ctrl_sync_edge_det.sv
// One-flop sampler of a camera sync line with rise/fall pulses judged against the
// previous sample.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Write-side sequencer for the dual-port frame buffer: writes one camera frame at
// consecutive addresses. Optional 2:1 decimation in both axes via CAM_CAPTURE_DECIM_EN.
module cam_capture_ctrl
  import cam_capture_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          cont,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic          px_valid,
  input  logic [DW-1:0] px_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  output logic          busy,
  output logic          done,
  output logic          err_short,
  output logic [AW-1:0] px_count
);

  localparam int            IMG_SIZE = img_size(IMG_W, IMG_H);
  localparam logic [AW-1:0] LAST_IDX = AW'(IMG_SIZE - 1);

  cap_state_e state, state_nxt;
  logic       vs_rise, vs_fall;
  logic       accept, write_ok;
  logic       arm, wr_fire, full_end, short_end;

  sync_edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (cam_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  assign accept = px_valid & cam_href;

`ifdef CAM_CAPTURE_DECIM_EN
  logic hr_rise, hr_fall;
  logic pix_par, line_par, pix_par_eff;

  sync_edge_det u_hr_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (cam_href),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  // The first pixel of a line may coincide with href rising; it counts as even.
  assign pix_par_eff = hr_rise ? 1'b0 : pix_par;
  assign write_ok    = accept & ~pix_par_eff & ~line_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_par  <= 1'b0;
      line_par <= 1'b0;
    end else begin
      pix_par  <= pix_par_eff ^ accept;
      line_par <= vs_fall ? 1'b0 : (line_par ^ hr_fall);
    end
  end
`else
  assign write_ok = accept;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    wr_fire   = 1'b0;
    full_end  = 1'b0;
    short_end = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WAIT_VS;
          arm       = 1'b1;
        end
      end
      ST_WAIT_VS: begin
        if (vs_fall) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          state_nxt = ST_DONE;
          short_end = 1'b1;
        end else if (write_ok) begin
          wr_fire = 1'b1;
          if (px_count == LAST_IDX) begin
            state_nxt = ST_DONE;
            full_end  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start || cont) begin
          state_nxt = ST_WAIT_VS;
          arm       = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      arm       = 1'b0;
      wr_fire   = 1'b0;
      full_end  = 1'b0;
      short_end = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err_short <= 1'b0;
      px_count  <= '0;
    end else begin
      mem_we <= wr_fire;
      if (arm) begin
        mem_addr  <= '0;
        px_count  <= '0;
        done      <= 1'b0;
        err_short <= 1'b0;
      end else if (wr_fire) begin
        mem_addr <= px_count;
        mem_data <= px_data;
        px_count <= px_count + 1'b1;
      end
      if (abort)                      done      <= 1'b0;
      else if (full_end || short_end) done      <= 1'b1;
      // Reaching vsync rise while still capturing always means the frame was short.
      if (short_end)                  err_short <= 1'b1;
    end
  end

  assign busy = (state == ST_WAIT_VS) || (state == ST_CAPTURE);

endmodule
